// File: rtl/myver_sweep_ctrl_pkg.sv
// Shared types and constants for the MyVer truth-table sweep controller.
package myver_sweep_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic MODE_BIN = 1'b0;
  localparam logic MODE_WGT = 1'b1;

  // Weight order {A,B,C}: entry 0 is the least significant element.
  localparam logic [7:0][2:0] WGT_ORDER = {3'b111, 3'b011, 3'b101, 3'b110,
                                           3'b001, 3'b010, 3'b100, 3'b000};

endpackage

// File: rtl/myver_sweep_ctrl_vec_rom.sv
// Maps a sweep step to the {A,B,C} vector for the selected order.
module myver_vec_rom
  import myver_sweep_ctrl_pkg::*;
(
  input  logic [2:0] step,
  input  logic       mode,
  output logic [2:0] vec
);

  always_comb begin
    vec = step;
    if (mode == MODE_WGT) vec = WGT_ORDER[step];
  end

endmodule

// File: rtl/myver_sweep_ctrl.sv
// Sweeps all 8 input vectors of MyVer, builds its truth table and compares
// it against an expected table latched at start.
module myver_sweep_ctrl
  import myver_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       mode,
  input  logic [7:0] exp_table,
  input  logic       f,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt,
  output logic [3:0] ones,
  output logic       pass
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [2:0] step_q,  step_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [7:0] work_q,  work_d;
  logic       mode_q,  mode_d;
  logic [7:0] exp_q,   exp_d;
  logic [7:0] tt_q,    tt_d;
  logic [3:0] ones_q,  ones_d;
  logic       pass_q,  pass_d;
  logic [2:0] vec;

  myver_vec_rom u_rom (
    .step (step_q),
    .mode (mode_q),
    .vec  (vec)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    mode_d  = mode_q;
    exp_d   = exp_q;
    tt_d    = tt_q;
    ones_d  = ones_q;
    pass_d  = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_APPLY;
          mode_d  = mode;
          exp_d   = exp_table;
          step_d  = '0;
          cnt_d   = '0;
          work_d  = '0;
        end
      end
      ST_APPLY: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d       = '0;
          work_d[vec] = f;
          if (step_q == 3'd7) begin
            // Commit uses the table including this final sample.
            state_d = ST_DONE;
            tt_d    = work_d;
            pass_d  = (work_d == exp_q);
            ones_d  = '0;
            for (int unsigned i = 0; i < 8; i++) ones_d = ones_d + 4'(work_d[i]);
          end else begin
            step_d = step_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      cnt_q   <= '0;
      work_q  <= '0;
      mode_q  <= MODE_BIN;
      exp_q   <= '0;
      tt_q    <= '0;
      ones_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      exp_q   <= exp_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
      pass_q  <= pass_d;
    end
  end

  assign {A, B, C} = (state_q == ST_APPLY) ? vec : 3'b000;
  assign busy = (state_q == ST_APPLY);
  assign done = (state_q == ST_DONE);
  assign tt   = tt_q;
  assign ones = ones_q;
  assign pass = pass_q;

endmodule

// File: tb/tb_myver_sweep_ctrl.sv
// Directed scoreboard bench for myver_sweep_ctrl with a behavioural MyVer model.
module tb_myver_sweep_ctrl;

  localparam int SETTLE_A = 4;

  typedef struct {
    logic [7:0] tt;
    logic [3:0] ones;
    logic       pass;
  } res_t;

  logic clk = 1'b0;
  logic rst, start, abort, mode, fsel;
  logic [7:0] exp_table;
  logic f, A, B, C, busy, done, pass;
  logic [7:0] tt;
  logic [3:0] ones;

  logic start2, abort2, f2, A2, B2, C2, busy2, done2, pass2;
  logic [7:0] tt2;
  logic [3:0] ones2;

  int checks = 0;
  int errors = 0;

  logic [2:0] vq[$];
  res_t       rq[$];
  int         hold = 0;
  logic [2:0] cur = 3'b000;

  always #5 clk = ~clk;

  function automatic logic fmodel(input logic sel, input logic [2:0] v);
    return sel ? ((v[2] & v[1]) | v[0]) : (v[2] ^ v[1] ^ v[0]);
  endfunction

  assign f  = fmodel(fsel, {A, B, C});
  assign f2 = A2 ^ B2 ^ C2;

  myver_sweep_ctrl #(.SETTLE(SETTLE_A)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .exp_table(exp_table), .f(f), .A(A), .B(B), .C(C), .busy(busy),
    .done(done), .tt(tt), .ones(ones), .pass(pass)
  );

  myver_sweep_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .mode(1'b0),
    .exp_table(8'h96), .f(f2), .A(A2), .B(B2), .C(C2), .busy(busy2),
    .done(done2), .tt(tt2), .ones(ones2), .pass(pass2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue the expected vector order and committed result, then pulse start.
  task automatic begin_sweep(input logic fs, input logic md, input logic [7:0] et);
    logic [2:0] wgt [8];
    res_t r;
    wgt = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b110, 3'b101, 3'b011, 3'b111};
    r.tt = '0;
    r.ones = '0;
    for (int i = 0; i < 8; i++) begin
      vq.push_back(md ? wgt[i] : 3'(i));
      r.tt[i] = fmodel(fs, 3'(i));
      r.ones  = r.ones + 4'(r.tt[i]);
    end
    r.pass = (r.tt == et);
    rq.push_back(r);
    fsel = fs; mode = md; exp_table = et;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 32'(done), 1);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Scoreboard: one vector popped per SETTLE busy cycles, result popped on done.
  always @(negedge clk) begin
    if (busy === 1'b1) begin
      if (hold % SETTLE_A == 0) begin
        chk("vec_avail", 32'(vq.size() > 0), 1);
        if (vq.size() > 0) cur = vq.pop_front();
      end
      chk("vec", 32'({A, B, C}), 32'(cur));
      hold++;
    end else if (done === 1'b1) begin
      chk("done_expected", 32'(rq.size() > 0), 1);
      if (rq.size() > 0) begin
        res_t r;
        r = rq.pop_front();
        chk("tt", 32'(tt), 32'(r.tt));
        chk("ones", 32'(ones), 32'(r.ones));
        chk("pass", 32'(pass), 32'(r.pass));
      end
      chk("latency", hold, 8 * SETTLE_A);
      chk("busy_on_done", 32'(busy), 0);
      chk("abc_on_done", 32'({A, B, C}), 0);
      hold = 0;
    end else begin
      hold = 0;
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; fsel = 1'b0;
    exp_table = '0; start2 = 1'b0; abort2 = 1'b0;
    cycles(3);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tt", 32'(tt), 0);
    chk("rst_ones", 32'(ones), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_abc", 32'({A, B, C}), 0);
    cycles(2);

    // XOR function, binary order.
    begin_sweep(1'b0, 1'b0, 8'h96);
    wait_done();
    cycles(1);
    chk("idle_after_done", 32'({busy, done}), 0);

    // Abort mid-sweep keeps the previous results.
    begin_sweep(1'b1, 1'b1, 8'hEA);
    cycles(12);
    abort = 1'b1;
    cycles(1);
    abort = 1'b0;
    vq.delete(); rq.delete();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_abc", 32'({A, B, C}), 0);
    chk("abort_tt", 32'(tt), 32'h96);
    cycles(40);
    chk("abort_no_done_pass", 32'(pass), 1);
    begin_sweep(1'b0, 1'b0, 8'h96);
    wait_done();
    cycles(2);

    // Weight order, matching and mismatching expectations.
    begin_sweep(1'b1, 1'b1, 8'hEA);
    wait_done();
    cycles(2);
    begin_sweep(1'b1, 1'b1, 8'hEB);
    wait_done();
    cycles(2);

    // Starts while busy and on the done cycle are ignored (and do not re-latch).
    begin_sweep(1'b0, 1'b0, 8'h96);
    cycles(4);
    mode = 1'b1; exp_table = 8'h00; start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(14);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    wait_done();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    chk("done_start_ignored", 32'({busy, done}), 0);
    cycles(10);
    chk("still_idle", 32'(busy), 0);

    // Synchronous reset mid-sweep.
    begin_sweep(1'b1, 1'b0, 8'hEA);
    cycles(9);
    rst = 1'b1;
    cycles(1);
    vq.delete(); rq.delete();
    chk("mid_rst_all", 32'({A, B, C, busy, done, tt, ones, pass}), 0);
    rst = 1'b0;
    cycles(2);

    // Simultaneous start and abort in IDLE.
    start = 1'b1; abort = 1'b1;
    cycles(1);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 0);
    cycles(3);
    chk("start_abort_stay", 32'(busy), 0);

    // SETTLE=1 instance: done eight edges after the start edge.
    start2 = 1'b1;
    cycles(1);
    start2 = 1'b0;
    begin
      int n = 0;
      while (done2 !== 1'b1 && n < 50) begin
        cycles(1);
        n++;
      end
      chk("s1_latency", n, 8);
      chk("s1_tt", 32'(tt2), 32'h96);
      chk("s1_pass", 32'(pass2), 1);
      chk("s1_ones", 32'(ones2), 4);
    end
    cycles(3);

    chk("queues_drained", 32'(vq.size() + rq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
